cache_controller: RTL
=====================

Name: cache_controller

Overview:
- Two-way set-associative, write-through, no-write-allocate data cache between the MEM stage and sram_controller.
- Upstream: single-word load/store requests with a ready/stall handshake.
- Downstream: drives the sram_controller wrEn/rdEn/address/writeData interface and consumes its 64-bit readData and ready.
- Line = 64 bits (two 32-bit words), filled by one SRAM read burst.

Parameters:
- BASE_ADDR, 1024, data-memory base; cache offset a = address - BASE_ADDR.
- SET_W, 6, index width; 64 sets. Index = a[8:3], word select = a[2].
- TAG_W, 10, tag = a[18:9].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- address  in  32  byte address, word-aligned.
- wdata  in  32  store data.
- rdata  out  32  load data; valid when ready=1 for a load.
- ready  out  1  1 = request done or no request; 0 = stall pipeline.
- sram_wrEn  out  1  SRAM write request.
- sram_rdEn  out  1  SRAM read request.
- sram_address  out  32  to sram_controller; fills use {address[31:3],3'b000}.
- sram_writeData  out  32  equals wdata.
- sram_readData  in  64  {word1, word0}; word0 is at the lower address.
- sram_ready  in  1  from sram_controller.

Behaviour:
- Reset, asynchronous on rst_n=0:
  - State = IDLE.
  - All valid bits cleared; all LRU bits = 0.
  - sram_wrEn = sram_rdEn = 0; ready = 1; rdata = 0.
  - Applies mid-burst: the outstanding SRAM transaction is abandoned (sram_controller is reset alongside).
- Storage per set: 2 ways × {valid, tag[TAG_W], data[63:0]}, plus lru (1 bit = next victim way).
- Hit: valid & tag match in either way. Both ways matching is impossible by construction.
- Requests: upstream holds mem_*_en, address and wdata stable until ready=1. mem_w_en has priority over mem_r_en.
- States:
  - IDLE
    - No request: ready=1.
    - Read hit: ready=1 in the same cycle (0-cycle latency). rdata = hit way word a[2]. lru <= ~hit_way.
    - Read miss: ready=0, go to FILL.
    - Write: ready=0, go to WRITE. On a write hit, word a[2] of the hit way is updated at this clock edge and lru <= ~hit_way. On a write miss the cache is unchanged.
  - FILL
    - sram_rdEn=1 and ready=0 until sram_ready=1.
    - In the sram_ready=1 cycle:
      - Victim = invalid way if any (way0 first), else lru.
      - Write sram_readData, tag, valid=1 into the victim; lru <= ~victim.
      - ready=1; rdata = sram_readData word a[2] (bypass).
      - Go to IDLE, so sram_rdEn drops the next cycle.
  - WRITE
    - sram_wrEn=1 and ready=0 until sram_ready=1.
    - In that cycle ready=1; go to IDLE.
- sram_rdEn and sram_wrEn are Moore outputs, never both 1. Outside FILL/WRITE, sram_address still follows address.
- sram_ready is ignored in IDLE.
- A request dropped by upstream while in FILL/WRITE is still completed; the result is discarded.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Read hit in IDLE: hit_count += 1.
  - Read miss entering FILL: miss_count += 1.
  - Writes are not counted. Both counters wrap at 16'hFFFF→0 and reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle -> ready=1, sram_rdEn=0, sram_wrEn=0; read of 1024 misses.
- Read 1024 (cold), SRAM model returns 64'h22222222_11111111 -> FILL until sram_ready, rdata=32'h11111111 with ready=1. Then read 1028 -> hit in the same cycle, rdata=32'h22222222, sram_rdEn stays 0.
- Write 0xDEADBEEF to 1028 after that fill -> sram_wrEn=1 until sram_ready, sram_writeData=0xDEADBEEF. Then read 1028 -> hit, rdata=0xDEADBEEF. Write 0x1234 to 2048 (miss, no allocate), then read 2048 -> miss.
- Addresses 1024, 1536, 2048 (same index 0, different tags): fill A, fill B, read A (hit), fill C -> C evicts B. Read A hits; read B misses.
- Reset pulse (rst_n=0 one cycle) mid-FILL -> immediately IDLE, sram_rdEn=0, ready=1. Reread of a previously cached address misses.
- Simultaneous mem_r_en=mem_w_en=1 at 1024 -> WRITE path taken, no FILL. With CACHE_STATS_EN: after scenario 2, hit_count=1, miss_count=1.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller
//   Two-way set-associative, write-through, no-write-allocate data cache
//   sitting between the MEM stage and sram_controller. A line is 64 bits
//   (two 32-bit words) and is filled by a single SRAM read burst.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   mem_r_en, mem_w_en  load / store request (store wins if both set)
//   address, wdata      word-aligned byte address, store data
//   rdata, ready        load data, done/stall handshake to the pipeline
//   sram_wrEn/rdEn      SRAM write / read request (Moore, never both set)
//   sram_address        SRAM address (line-aligned during fills)
//   sram_writeData      store data forwarded to SRAM
//   sram_readData       {word1, word0} fill data
//   sram_ready          SRAM transaction complete
//   hit_count/miss_count  read hit/miss counters, present only when the
//                         CACHE_STATS_EN macro is defined
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | serve hits combinationally, launch fills and writes
// S_FILL  | SRAM line read outstanding; victim written on sram_ready
// S_WRITE | SRAM write-through outstanding
module cache_controller #(
   parameter int BASE_ADDR = 1024,
   parameter int SET_W     = 6,
   parameter int TAG_W     = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [31:0] address,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        sram_wrEn,
   output logic        sram_rdEn,
   output logic [31:0] sram_address,
   output logic [31:0] sram_writeData,
   input  logic [63:0] sram_readData,
   input  logic        sram_ready
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   localparam int SETS = 1 << SET_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   logic [1:0]  state, state_nxt;
   logic [31:0] req_addr;

   logic [SETS-1:0]  valid0, valid1, lru;
   logic [TAG_W-1:0] tag0  [SETS];
   logic [TAG_W-1:0] tag1  [SETS];
   logic [63:0]      data0 [SETS];
   logic [63:0]      data1 [SETS];

   // Outside IDLE the request address is taken from the copy latched when
   // the transaction started, so a request dropped mid-transaction still
   // completes against the line it was issued for.
   logic [31:0]      cur_addr, cur_off;
   logic [SET_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic             word_sel;

   assign cur_addr = (state == S_IDLE) ? address : req_addr;
   assign cur_off  = cur_addr - 32'(BASE_ADDR);
   assign idx      = cur_off[SET_W+2:3];
   assign tag      = cur_off[SET_W+TAG_W+2:SET_W+3];
   assign word_sel = cur_off[2];

   logic unused_off_bits;
   assign unused_off_bits = ^{cur_off[31:SET_W+TAG_W+3], cur_off[1:0]};

   logic        hit0, hit1, hit, hit_way, victim;
   logic [63:0] hit_line;
   logic [31:0] hit_word, fill_word;

   assign hit0      = valid0[idx] && (tag0[idx] == tag);
   assign hit1      = valid1[idx] && (tag1[idx] == tag);
   assign hit       = hit0 || hit1;
   assign hit_way   = hit1;
   assign hit_line  = hit1 ? data1[idx] : data0[idx];
   assign hit_word  = word_sel ? hit_line[63:32] : hit_line[31:0];
   assign fill_word = word_sel ? sram_readData[63:32] : sram_readData[31:0];
   // Invalid ways are filled first (way0 before way1); otherwise evict LRU.
   assign victim    = !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);

   logic upd_lru, lru_val, wr_hit, fill, rd_hit_evt, rd_miss_evt;

   always_comb begin
      state_nxt   = state;
      ready       = 1'b1;
      rdata       = 32'd0;
      upd_lru     = 1'b0;
      lru_val     = 1'b0;
      wr_hit      = 1'b0;
      fill        = 1'b0;
      rd_hit_evt  = 1'b0;
      rd_miss_evt = 1'b0;
      case (state)
         S_IDLE: begin
            if (mem_w_en) begin
               ready     = 1'b0;
               state_nxt = S_WRITE;
               if (hit) begin
                  wr_hit  = 1'b1;
                  upd_lru = 1'b1;
                  lru_val = ~hit_way;
               end
            end else if (mem_r_en) begin
               if (hit) begin
                  rdata      = hit_word;
                  upd_lru    = 1'b1;
                  lru_val    = ~hit_way;
                  rd_hit_evt = 1'b1;
               end else begin
                  ready       = 1'b0;
                  state_nxt   = S_FILL;
                  rd_miss_evt = 1'b1;
               end
            end
         end
         S_FILL: begin
            if (sram_ready) begin
               fill      = 1'b1;
               upd_lru   = 1'b1;
               lru_val   = ~victim;
               rdata     = fill_word;
               state_nxt = S_IDLE;
            end else begin
               ready = 1'b0;
            end
         end
         S_WRITE: begin
            if (sram_ready) state_nxt = S_IDLE;
            else            ready     = 1'b0;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign sram_rdEn      = (state == S_FILL);
   assign sram_wrEn      = (state == S_WRITE);
   assign sram_address   = (state == S_FILL) ? {cur_addr[31:3], 3'b000} : cur_addr;
   assign sram_writeData = wdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         req_addr <= 32'd0;
         valid0   <= '0;
         valid1   <= '0;
         lru      <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE) req_addr <= address;
         if (upd_lru) lru[idx] <= lru_val;
         if (fill) begin
            if (victim) valid1[idx] <= 1'b1;
            else        valid0[idx] <= 1'b1;
         end
      end
   end

   // Tag/data storage carries no reset; valid bits gate every use.
   always_ff @(posedge clk) begin
      if (fill) begin
         if (victim) begin
            tag1[idx]  <= tag;
            data1[idx] <= sram_readData;
         end else begin
            tag0[idx]  <= tag;
            data0[idx] <= sram_readData;
         end
      end else if (wr_hit) begin
         if (hit_way) begin
            if (word_sel) data1[idx][63:32] <= wdata;
            else          data1[idx][31:0]  <= wdata;
         end else begin
            if (word_sel) data0[idx][63:32] <= wdata;
            else          data0[idx][31:0]  <= wdata;
         end
      end
   end

`ifdef CACHE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= 16'd0;
         miss_count <= 16'd0;
      end else begin
         if (rd_hit_evt)  hit_count  <= hit_count + 16'd1;
         if (rd_miss_evt) miss_count <= miss_count + 16'd1;
      end
   end
`else
   logic unused_stat_evts;
   assign unused_stat_evts = rd_hit_evt ^ rd_miss_evt;
`endif

endmodule
